// File: rtl/hh_mod_pkg.sv
// Shared definitions for the codeword modulator: FSM state encoding and
// default geometry (preamble length, chips per bit, payload word width).
package hh_mod_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DONE     = 2'd3
    } hh_state_t;

    localparam int unsigned HH_PREAMBLE_LEN  = 48;
    localparam int unsigned HH_CHIPS_PER_BIT = 33;
    localparam int unsigned HH_DATA_W        = 10;

endpackage

// File: rtl/hh_word_shifter.sv
// Payload word shifter: holds the word being sent (MSB first) and the index
// of the bit currently on air.
// Ports:
//   clock, reset (async, active-low)
//   clear      - drop back to bit 0 (packet abort)
//   load       - capture data, restart at bit 0
//   shift      - advance to the next bit
//   data       - word to load
//   cur_bit    - bit currently being modulated (shreg MSB)
//   last_bit_c - high while the final bit of the word is on air
module hh_word_shifter #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              cur_bit,
    output logic              last_bit_c
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;

    // Clear has priority so an abort never leaves a stale bit position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= data;
            bit_idx <= '0;
        end else if (shift) begin
            shreg   <= shreg << 1;
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    assign cur_bit    = shreg[DATA_W-1];
    assign last_bit_c = (bit_idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/hh_codeword_modulator.sv
// Backscatter codeword modulator: toggling preamble followed by a gapless
// stream of payload words, each bit spread over CHIPS_PER_BIT chips
// (toggle bit flips mod_out every chip, hold bit keeps it constant).
// Ports:
//   clock, reset (async, active-low)
//   trigger    - packet enable level; low aborts from any state
//   invert     - 0: data 1 toggles, 1: data 0 toggles
//   in_data/in_valid/in_last/in_ready - word handshake (in_ready is
//                combinational from registered state)
//   mod_out    - RF switch drive
//   busy       - packet in PREAMBLE or PAYLOAD
//   done       - one-cycle pulse on normal completion
//   underrun   - sticky: no word offered at a word boundary
//   words_sent - completed words in this packet (wraps)
module hh_codeword_modulator
    import hh_mod_pkg::*;
#(
    parameter int unsigned DATA_W        = HH_DATA_W,
    parameter int unsigned PREAMBLE_LEN  = HH_PREAMBLE_LEN,
    parameter int unsigned CHIPS_PER_BIT = HH_CHIPS_PER_BIT,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger,
    input  logic              invert,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mod_out,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [7:0]        words_sent
);

    hh_state_t        state;
    logic [CNT_W-1:0] chip_cnt;
    logic             last_q;

    logic cur_bit;
    logic last_bit_c;
    logic pre_last_c;
    logic chip_last_c;
    logic accept_c;
    logic load_c;
    logic shift_c;

    assign pre_last_c  = (chip_cnt >= CNT_W'(PREAMBLE_LEN - 1));
    assign chip_last_c = (chip_cnt == CNT_W'(CHIPS_PER_BIT - 1));

    // Ready only on the final preamble chip or the final chip of a
    // non-last word, so the next word starts with no bubble.
    assign in_ready = ((state == PREAMBLE) && (chip_cnt == CNT_W'(PREAMBLE_LEN - 1)))
                   || ((state == PAYLOAD) && chip_last_c && last_bit_c && !last_q);
    assign accept_c = in_valid && in_ready;
    assign load_c   = trigger && accept_c;
    assign shift_c  = trigger && (state == PAYLOAD) && chip_last_c && !last_bit_c;

    hh_word_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .clear      (!trigger),
        .load       (load_c),
        .shift      (shift_c),
        .data       (in_data),
        .cur_bit    (cur_bit),
        .last_bit_c (last_bit_c)
    );

    // Packet FSM, chip counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            chip_cnt   <= '0;
            last_q     <= 1'b0;
            mod_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            words_sent <= '0;
        end else begin
            done <= 1'b0;
            if (!trigger) begin
                // Abort: status flags are kept for inspection until next start.
                state    <= IDLE;
                chip_cnt <= '0;
                last_q   <= 1'b0;
                mod_out  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        mod_out    <= ~mod_out;
                        chip_cnt   <= CNT_W'(1);
                        state      <= PREAMBLE;
                        busy       <= 1'b1;
                        underrun   <= 1'b0;
                        words_sent <= '0;
                    end
                    PREAMBLE: begin
                        mod_out  <= ~mod_out;
                        chip_cnt <= chip_cnt + CNT_W'(1);
                        if (pre_last_c) begin
                            if (accept_c) begin
                                state    <= PAYLOAD;
                                chip_cnt <= '0;
                                last_q   <= in_last;
                            end else begin
                                underrun <= 1'b1;
                                state    <= DONE;
                                busy     <= 1'b0;
                                mod_out  <= 1'b0;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (cur_bit ^ invert) begin
                            mod_out <= ~mod_out;
                        end
                        chip_cnt <= chip_cnt + CNT_W'(1);
                        if (chip_last_c) begin
                            chip_cnt <= '0;
                            if (last_bit_c) begin
                                words_sent <= words_sent + 8'd1;
                                if (last_q) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end else if (accept_c) begin
                                    last_q <= in_last;
                                end else begin
                                    underrun <= 1'b1;
                                    state    <= DONE;
                                    busy     <= 1'b0;
                                end
                            end
                        end
                    end
                    DONE: begin
                        mod_out <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hh_codeword_modulator.sv
// Directed bench for hh_codeword_modulator: default geometry plus a small
// (4-chip preamble, 1 chip/bit, 4-bit word) instance. Edge k is the k-th
// rising edge after trigger goes high; outputs are sampled 1 ns after it.
module tb_hh_codeword_modulator;

    logic       clock;
    logic       reset;

    logic       trigger;
    logic       invert;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       mod_out;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [7:0] words_sent;

    logic       s_trigger;
    logic       s_invert;
    logic [3:0] s_in_data;
    logic       s_in_valid;
    logic       s_in_last;
    logic       s_in_ready;
    logic       s_mod_out;
    logic       s_busy;
    logic       s_done;
    logic       s_underrun;
    logic [7:0] s_words_sent;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    logic trace_mo   [0:1023];
    logic trace_done [0:1023];
    logic rdy_at     [0:1023];

    hh_codeword_modulator dut (
        .clock      (clock),
        .reset      (reset),
        .trigger    (trigger),
        .invert     (invert),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mod_out    (mod_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .words_sent (words_sent)
    );

    hh_codeword_modulator #(
        .DATA_W        (4),
        .PREAMBLE_LEN  (4),
        .CHIPS_PER_BIT (1),
        .CNT_W         (2)
    ) dut_small (
        .clock      (clock),
        .reset      (reset),
        .trigger    (s_trigger),
        .invert     (s_invert),
        .in_data    (s_in_data),
        .in_valid   (s_in_valid),
        .in_last    (s_in_last),
        .in_ready   (s_in_ready),
        .mod_out    (s_mod_out),
        .busy       (s_busy),
        .done       (s_done),
        .underrun   (s_underrun),
        .words_sent (s_words_sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges, tracing in_ready seen by each edge and the outputs after it.
    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            if (edge_n < 1022) rdy_at[edge_n + 1] = in_ready;
            @(posedge clock);
            #1;
            if (edge_n < 1022) edge_n++;
            trace_mo[edge_n]   = mod_out;
            trace_done[edge_n] = done;
        end
    endtask

    task automatic start_packet();
        edge_n      = 0;
        trace_mo[0] = mod_out;
        trigger     = 1'b1;
    endtask

    function automatic int toggles(input int a, input int b);
        int t = 0;
        for (int k = a; k <= b; k++) if (trace_mo[k] != trace_mo[k-1]) t++;
        return t;
    endfunction

    function automatic int first_done();
        for (int k = 1; k <= edge_n; k++) if (trace_done[k]) return k;
        return -1;
    endfunction

    function automatic int count_done();
        int c = 0;
        for (int k = 1; k <= edge_n; k++) if (trace_done[k]) c++;
        return c;
    endfunction

    function automatic int count_ready();
        int c = 0;
        for (int k = 1; k <= edge_n; k++) if (rdy_at[k]) c++;
        return c;
    endfunction

    initial begin
        logic [7:0] seq;
        logic       d7;
        logic       d8;
        logic       d9;
        logic       r4;

        reset      = 1'b0;
        trigger    = 1'b0;
        invert     = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        s_trigger  = 1'b0;
        s_invert   = 1'b0;
        s_in_data  = '0;
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        #23;
        check("rst_mod_out", 32'(mod_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_words", 32'(words_sent), 0);
        check("rst_ready", 32'(in_ready), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // One word 10'b1000000001, last.
        in_data  = 10'b1000000001;
        in_valid = 1'b1;
        in_last  = 1'b1;
        start_packet();
        run_edges(1);
        check("w1_busy_e1", 32'(busy), 1);
        run_edges(379);
        check("w1_pre_toggles", 32'(toggles(1, 48)), 48);
        check("w1_pre_end", 32'(trace_mo[48]), 0);
        check("w1_bit9_toggles", 32'(toggles(49, 81)), 33);
        check("w1_hold_toggles", 32'(toggles(82, 345)), 0);
        check("w1_hold_level", 32'(trace_mo[345]), 1);
        check("w1_bit0_toggles", 32'(toggles(346, 378)), 33);
        check("w1_done_edge", 32'(first_done()), 378);
        check("w1_done_count", 32'(count_done()), 1);
        check("w1_words", 32'(words_sent), 1);
        check("w1_underrun", 32'(underrun), 0);
        check("w1_busy_end", 32'(busy), 0);
        check("w1_mod_end", 32'(mod_out), 0);
        trigger = 1'b0;
        run_edges(2);

        // Two words 3FF then 000, valid held high.
        in_data = 10'h3FF;
        in_last = 1'b0;
        start_packet();
        run_edges(48);
        in_data = 10'h000;
        in_last = 1'b1;
        run_edges(662);
        check("w2_ready_count", 32'(count_ready()), 2);
        check("w2_ready_e48", 32'(rdy_at[48]), 1);
        check("w2_ready_e378", 32'(rdy_at[378]), 1);
        check("w2_word1_toggles", 32'(toggles(49, 378)), 330);
        check("w2_word2_toggles", 32'(toggles(379, 708)), 0);
        check("w2_done_edge", 32'(first_done()), 708);
        check("w2_words", 32'(words_sent), 2);
        trigger = 1'b0;
        run_edges(2);

        // Underrun at the first word boundary.
        in_data  = 10'h3FF;
        in_last  = 1'b0;
        in_valid = 1'b1;
        start_packet();
        run_edges(48);
        in_valid = 1'b0;
        run_edges(332);
        check("ur_underrun", 32'(underrun), 1);
        check("ur_done_count", 32'(count_done()), 0);
        check("ur_mod_out", 32'(mod_out), 0);
        check("ur_busy", 32'(busy), 0);
        check("ur_words", 32'(words_sent), 1);
        trigger = 1'b0;
        run_edges(2);
        check("ur_hold_after_abort", 32'(underrun), 1);
        check("ur_words_hold", 32'(words_sent), 1);

        // Abort at edge 100, then retrigger with invert=1 and word 000.
        in_data  = 10'h3FF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        start_packet();
        run_edges(1);
        check("ab_underrun_clr", 32'(underrun), 0);
        check("ab_words_clr", 32'(words_sent), 0);
        check("ab_mod_e1", 32'(mod_out), 1);
        run_edges(98);
        check("ab_busy_e99", 32'(busy), 1);
        trigger = 1'b0;
        run_edges(1);
        check("ab_mod_out", 32'(mod_out), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_ready", 32'(in_ready), 0);
        check("ab_done_count", 32'(count_done()), 0);

        invert  = 1'b1;
        in_data = 10'h000;
        start_packet();
        run_edges(380);
        check("inv_pre_toggles", 32'(toggles(1, 48)), 48);
        check("inv_payload_toggles", 32'(toggles(49, 378)), 330);
        check("inv_done_edge", 32'(first_done()), 378);
        check("inv_words", 32'(words_sent), 1);
        trigger = 1'b0;
        invert  = 1'b0;
        run_edges(2);

        // Async reset mid-preamble.
        start_packet();
        run_edges(21);
        check("ar_mod_before", 32'(mod_out), 1);
        check("ar_busy_before", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_mod_out", 32'(mod_out), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_ready", 32'(in_ready), 0);
        check("ar_words", 32'(words_sent), 0);
        trigger = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Small geometry: word 1010 -> preamble 1,0,1,0 then 1,1,0,0.
        s_in_data  = 4'b1010;
        s_in_valid = 1'b1;
        s_in_last  = 1'b1;
        s_trigger  = 1'b1;
        seq = '0;
        d7  = 1'b0;
        d8  = 1'b0;
        d9  = 1'b0;
        r4  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) r4 = s_in_ready;
            @(posedge clock);
            #1;
            if (k <= 8) seq = {seq[6:0], s_mod_out};
            if (k == 7) d7 = s_done;
            if (k == 8) d8 = s_done;
            if (k == 9) d9 = s_done;
        end
        check("sm_sequence", 32'(seq), 32'(8'b1010_1100));
        check("sm_ready_e4", 32'(r4), 1);
        check("sm_done_e7", 32'(d7), 0);
        check("sm_done_e8", 32'(d8), 1);
        check("sm_done_e9", 32'(d9), 0);
        check("sm_words", 32'(s_words_sent), 1);
        check("sm_mod_end", 32'(s_mod_out), 0);
        s_trigger = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
